param_sync_fifo: RTL and testbench
==================================

Name: param_sync_fifo

Overview:
Parametrised single-clock FIFO. It replaces the fixed 16x32 queue controller with configurable width, depth and thresholds. It adds a full-depth occupancy count, simultaneous read/write in one cycle, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and an optional first-word-fall-through read mode. It sits between producer and consumer datapaths as the standard buffering element.

Parameters:
WIDTH, 32, data word width in bits (>=1).
DEPTH, 16, number of entries; power of two, >=4.
AF_LEVEL, 12, almost_full asserts when Count >= AF_LEVEL (1..DEPTH).
AE_LEVEL, 4, almost_empty asserts when Count <= AE_LEVEL (0..DEPTH-1).
FWFT, 0, 0 = registered read (one-cycle latency); 1 = first-word-fall-through.
AW, log2(DEPTH), derived localparam, pointer width.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-low reset.
In  input  WIDTH  write data.
write  input  1  write request.
read  input  1  read request (acknowledge in FWFT mode).
clr_err  input  1  synchronous clear of overflow/underflow.
Out  output  WIDTH  read data.
valid  output  1  Out holds a valid word.
empty  output  1  Count == 0.
full  output  1  Count == DEPTH.
half_full  output  1  Count >= DEPTH/2.
almost_full  output  1  Count >= AF_LEVEL.
almost_empty  output  1  Count <= AE_LEVEL.
Count  output  AW+1  current occupancy, 0..DEPTH.
overflow  output  1  sticky: a write was refused.
underflow  output  1  sticky: a read was refused.

Behaviour:
- Reset (rst low, asynchronous): read ptr, write ptr and Count = 0; Out = 0; valid = 0; overflow = underflow = 0. Flags therefore read empty=1, almost_empty=1, all others 0. Memory contents are not reset. Reset mid-operation discards all stored words immediately.
- Pointers: AW+1 bits each (wrap bit). Address is the low AW bits. Wrap from DEPTH-1 to 0 is natural modulo; no explicit compare.
- Count is a registered counter: +1 on accepted write only, -1 on accepted read only, unchanged on both or neither. All flags decode combinationally from the registered Count, so a flag reflects the state after the edge.
- rd_ok = read & ~empty.
- wr_ok = write & (~full | rd_ok). Writing while full is accepted only when a read is accepted in the same cycle; Count stays DEPTH.
- A read while empty is refused even if a write occurs in the same cycle (no bypass). The written word becomes readable the following cycle.
- FWFT=0: on rd_ok, Out <= mem[rd_ptr] at the edge and valid = 1 for that one cycle. Otherwise valid = 0 and Out holds its last value.
- FWFT=1: Out = mem[rd_ptr] combinationally and valid = ~empty. Asserting read with valid=1 consumes the word, and the next word appears after the edge. Out is don't-care when valid = 0.
- Errors: write & ~wr_ok sets overflow; read & empty sets underflow. Both are sticky. clr_err clears them at the edge. If set and clear occur in the same cycle, set wins.
- Refused operations never move pointers, Count or memory.

Test Plan:
- Reset then 16 writes 0x100..0x10F (DEPTH=16) -> Count steps 1..16; half_full at Count 8, almost_full at 12, full at 16, almost_empty deasserts at Count 5.
- 17th write 0xDEAD while full, no read -> refused; overflow=1, Count stays 16. Drain all 16 words -> Out 0x100..0x10F in order, each valid for one cycle after its read, empty=1 at end.
- Count=16, write+read together with In=0xAAAA -> oldest word out, Count stays 16, no overflow. Continue 20 cycles of write+read -> pointers wrap, data order preserved, Count constant.
- Empty FIFO, read+write same cycle with In=0x55 -> read refused, underflow=1, Count=1. Next cycle read -> Out=0x55. clr_err pulse -> underflow=0. Underflow event and clr_err in the same cycle -> underflow stays 1.
- FWFT=1: write 0x11 then 0x22 -> Out=0x11 and valid=1 in the cycle after the first write. read -> Out=0x22. read -> valid=0, empty=1.
- Fill to 10 words, drop rst asynchronously mid-cycle -> Count=0, empty=1, valid=0, Out=0 immediately without waiting for a clock edge. Release rst, write 0x77, read -> Out=0x77.

Source files
------------

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags, sticky
// overflow/underflow errors and an optional first-word-fall-through read port.
module param_sync_fifo #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = 12,
    parameter int unsigned AE_LEVEL = 4,
    parameter int unsigned FWFT     = 0,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] In,
    input  logic             write,
    input  logic             read,
    input  logic             clr_err,
    output logic [WIDTH-1:0] Out,
    output logic             valid,
    output logic             empty,
    output logic             full,
    output logic             half_full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      Count,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned CW      = AW + 1;
    localparam bit          FWFT_ON = (FWFT != 0);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      count_q;
    logic [WIDTH-1:0] out_q;
    logic             valid_q;
    logic             ovf_q;
    logic             unf_q;
    logic             rd_ok;
    logic             wr_ok;

    // Flags decode from the registered count, so they describe post-edge state
    always_comb begin
        empty        = (count_q == CW'(0));
        full         = (count_q == CW'(DEPTH));
        half_full    = (count_q >= CW'(DEPTH / 2));
        almost_full  = (count_q >= CW'(AF_LEVEL));
        almost_empty = (count_q <= CW'(AE_LEVEL));
    end

    // A full FIFO still accepts a write when a read frees a slot in the same cycle
    assign rd_ok = read & ~empty;
    assign wr_ok = write & (~full | rd_ok);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= In;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + CW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + CW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Registered read path; unused (and pruned) in fall-through mode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_ok;
            if (rd_ok) begin
                out_q <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    // Sticky errors: a new event in the same cycle as clr_err keeps the flag set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= (ovf_q & ~clr_err) | (write & ~wr_ok);
            unf_q <= (unf_q & ~clr_err) | (read & empty);
        end
    end

    assign Out       = FWFT_ON ? mem[rd_ptr[AW-1:0]] : out_q;
    assign valid     = FWFT_ON ? ~empty : valid_q;
    assign Count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: a registered-read instance checked with vector
// tables, hand sequences and random traffic against a queue model, plus a FWFT instance.
module tb_param_sync_fifo;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AF    = 12;
    localparam int unsigned AE    = 4;
    localparam int unsigned CW    = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] din, dout;
    logic             write, read, clr_err;
    logic             valid, empty, full, half_full, almost_full, almost_empty;
    logic             overflow, underflow;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] f_din, f_dout;
    logic             f_write, f_read;
    logic             f_valid, f_empty, f_full, f_hf, f_af, f_ae, f_ovf, f_unf;
    logic [CW-1:0]    f_count;

    param_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .In(din), .write(write), .read(read), .clr_err(clr_err),
        .Out(dout), .valid(valid), .empty(empty), .full(full), .half_full(half_full),
        .almost_full(almost_full), .almost_empty(almost_empty), .Count(count),
        .overflow(overflow), .underflow(underflow)
    );

    param_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dut_f (
        .clk(clk), .rst(rst), .In(f_din), .write(f_write), .read(f_read), .clr_err(1'b0),
        .Out(f_dout), .valid(f_valid), .empty(f_empty), .full(f_full), .half_full(f_hf),
        .almost_full(f_af), .almost_empty(f_ae), .Count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: a plain queue of words plus the visible read register
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_out;
    bit               m_valid, m_ovf, m_unf;

    typedef struct {
        bit               w, r, c;
        logic [WIDTH-1:0] d;
        int               cnt;
        bit [4:0]         flg;   // {empty, full, half_full, almost_full, almost_empty}
        bit               v;
        logic [WIDTH-1:0] o;
        bit               ovf, unf;
    } vec_t;

    vec_t tbl[35];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    function automatic bit [4:0] mkflg(int n);
        return {n == 0, n == int'(DEPTH), n >= int'(DEPTH / 2), n >= int'(AF), n <= int'(AE)};
    endfunction

    task automatic model_reset();
        q.delete();
        m_out = '0; m_valid = 0; m_ovf = 0; m_unf = 0;
    endtask

    // Drive one cycle on the registered-read DUT and advance the model alongside
    task automatic apply(bit w, bit r, bit c, logic [WIDTH-1:0] d);
        bit mt, rok, wok;
        write = w; read = r; clr_err = c; din = d;
        mt  = (q.size() == 0);
        rok = r && !mt;
        wok = w && (q.size() < DEPTH || rok);
        m_ovf = (m_ovf && !c) || (w && !wok);
        m_unf = (m_unf && !c) || (r && mt);
        m_valid = rok;
        if (rok) m_out = q.pop_front();
        if (wok) q.push_back(d);
        @(posedge clk);
        #1;
        write = 0; read = 0; clr_err = 0;
    endtask

    task automatic check_model();
        int n;
        n = q.size();
        check("count", 32'(count), 32'(n));
        check("flags", 32'({empty, full, half_full, almost_full, almost_empty}), 32'(mkflg(n)));
        check("valid", 32'(valid), 32'(m_valid));
        check("out", dout, m_out);
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
    endtask

    initial begin
        rst = 1'b0; write = 0; read = 0; clr_err = 0; din = '0;
        f_write = 0; f_read = 0; f_din = '0;
        model_reset();

        // Table: fill 16, refused 17th write, drain 16, idle, clear error
        for (int i = 0; i < 16; i++)
            tbl[i] = '{1, 0, 0, 32'h100 + 32'(i), i + 1, mkflg(i + 1), 0, 32'h0, 0, 0};
        tbl[16] = '{1, 0, 0, 32'hDEAD, 16, 5'b01110, 0, 32'h0, 1, 0};
        for (int j = 0; j < 16; j++)
            tbl[17 + j] = '{0, 1, 0, 32'h0, 15 - j, mkflg(15 - j), 1, 32'h100 + 32'(j), 1, 0};
        tbl[33] = '{0, 0, 0, 32'h0, 0, 5'b10001, 0, 32'h10F, 1, 0};
        tbl[34] = '{0, 0, 1, 32'h0, 0, 5'b10001, 0, 32'h10F, 0, 0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_flags", 32'({empty, full, half_full, almost_full, almost_empty}), 32'b10001);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_out", dout, 32'h0);
        check("rst_err", 32'({overflow, underflow}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 35; k++) begin
            apply(tbl[k].w, tbl[k].r, tbl[k].c, tbl[k].d);
            check($sformatf("tbl%0d_count", k), 32'(count), 32'(tbl[k].cnt));
            check($sformatf("tbl%0d_flags", k),
                  32'({empty, full, half_full, almost_full, almost_empty}), 32'(tbl[k].flg));
            check($sformatf("tbl%0d_valid", k), 32'(valid), 32'(tbl[k].v));
            check($sformatf("tbl%0d_out", k), dout, tbl[k].o);
            check($sformatf("tbl%0d_err", k), 32'({overflow, underflow}), 32'({tbl[k].ovf, tbl[k].unf}));
        end

        // Full FIFO: simultaneous write+read keeps Count at DEPTH and wraps pointers
        for (int i = 0; i < 16; i++) apply(1, 0, 0, 32'h200 + 32'(i));
        apply(1, 1, 0, 32'hAAAA);
        check("full_wr_rd_count", 32'(count), 32'd16);
        check("full_wr_rd_out", dout, 32'h200);
        check("full_wr_rd_valid", 32'(valid), 32'd1);
        check("full_wr_rd_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 20; i++) begin
            apply(1, 1, 0, 32'h300 + 32'(i));
            check_model();
        end
        for (int i = 0; i < 16; i++) begin
            apply(0, 1, 0, 32'h0);
            check_model();
        end
        check("drained_empty", 32'(empty), 32'd1);

        // Empty read with same-cycle write: no bypass, underflow set
        apply(1, 1, 0, 32'h55);
        check("unf_set", 32'(underflow), 32'd1);
        check("unf_count", 32'(count), 32'd1);
        check("unf_valid", 32'(valid), 32'd0);
        apply(0, 1, 0, 32'h0);
        check("unf_next_out", dout, 32'h55);
        check("unf_next_valid", 32'(valid), 32'd1);
        apply(0, 0, 1, 32'h0);
        check("unf_cleared", 32'(underflow), 32'd0);
        apply(0, 1, 1, 32'h0);
        check("unf_set_wins", 32'(underflow), 32'd1);
        check_model();
        apply(0, 0, 1, 32'h0);
        check_model();

        // Random traffic: write-biased then read-biased
        for (int i = 0; i < 400; i++) begin
            bit w, r, c;
            w = (i < 200) ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 35);
            r = (i < 200) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 65);
            c = ($urandom_range(0, 31) == 0);
            apply(w, r, c, $urandom);
            check_model();
        end

        // Asynchronous reset mid-cycle with valid data on Out
        apply(0, 0, 1, 32'h0);
        while (q.size() > 0) apply(0, 1, 0, 32'h0);
        for (int i = 0; i < 10; i++) apply(1, 0, 0, 32'h400 + 32'(i));
        apply(0, 1, 0, 32'h0);
        check("pre_rst_out", dout, 32'h400);
        check("pre_rst_count", 32'(count), 32'd9);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_empty", 32'(empty), 32'd1);
        check("async_rst_valid", 32'(valid), 32'd0);
        check("async_rst_out", dout, 32'h0);
        check("async_rst_ae", 32'(almost_empty), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        apply(1, 0, 0, 32'h77);
        apply(0, 1, 0, 32'h0);
        check("post_rst_out", dout, 32'h77);
        check_model();

        // First-word-fall-through instance
        check("fwft_idle_valid", 32'(f_valid), 32'd0);
        check("fwft_idle_empty", 32'(f_empty), 32'd1);
        f_write = 1; f_din = 32'h11;
        @(posedge clk); #1;
        check("fwft_first_valid", 32'(f_valid), 32'd1);
        check("fwft_first_out", f_dout, 32'h11);
        f_din = 32'h22;
        @(posedge clk); #1;
        check("fwft_hold_out", f_dout, 32'h11);
        check("fwft_count2", 32'(f_count), 32'd2);
        f_write = 0; f_read = 1;
        @(posedge clk); #1;
        check("fwft_second_out", f_dout, 32'h22);
        check("fwft_second_valid", 32'(f_valid), 32'd1);
        @(posedge clk); #1;
        f_read = 0;
        check("fwft_drained_valid", 32'(f_valid), 32'd0);
        check("fwft_drained_empty", 32'(f_empty), 32'd1);
        check("fwft_no_unf", 32'(f_unf), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
